// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI4-Stream arbiter slice.
package axis_pkg;

    // Index width that never collapses to zero bits for a single-entry vector.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i.
module axis_rr_pick
    import axis_pkg::*;
#(
    parameter int unsigned S_COUNT   = 4,
    parameter int unsigned SEL_WIDTH = clog2_safe(S_COUNT)
) (
    input  logic [S_COUNT-1:0]   req_i,
    input  logic [SEL_WIDTH-1:0] ptr_i,
    output logic [SEL_WIDTH-1:0] idx_o,
    output logic                 any_o
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < S_COUNT; k++) begin
            cand = (32'(ptr_i) + k) % S_COUNT;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = SEL_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arb.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream output among S_COUNT inputs.
module axis_rr_arb
    import axis_pkg::*;
#(
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = clog2_safe(S_COUNT),
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [SEL_WIDTH-1:0]          grant_idx,
    output logic                          grant_valid,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    logic                 state_q,     state_d;
    logic [SEL_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [SEL_WIDTH-1:0] ptr_q,       ptr_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_any;
    logic                 active;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 beat_last;
    logic [SEL_WIDTH-1:0] ptr_inc;

    axis_rr_pick #(
        .S_COUNT  (S_COUNT),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_pick (
        .req_i(s_axis_tvalid),
        .ptr_i(ptr_q),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    // Output mux and ready steering follow the held grant without buffering.
    always_comb begin
        active        = (state_q == ST_ACTIVE);
        sel_valid     = s_axis_tvalid[grant_idx_q];
        sel_last      = s_axis_tlast[grant_idx_q];
        m_axis_tdata  = s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid = active & sel_valid;
        m_axis_tlast  = sel_last;
        s_axis_tready = '0;
        if (active) begin
            s_axis_tready[grant_idx_q] = m_axis_tready;
        end
        beat_last = m_axis_tvalid & m_axis_tready & sel_last;
        ptr_inc   = (grant_idx_q == SEL_WIDTH'(S_COUNT - 1))
                  ? '0 : grant_idx_q + SEL_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        pkt_count_d = pkt_count_q;
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d     = ST_ACTIVE;
                grant_idx_d = pick_idx;
            end
        end else if (beat_last) begin
            // grant_idx is left as-is so software can see the last winner.
            state_d     = ST_IDLE;
            ptr_d       = ptr_inc;
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = state_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Randomized bench for axis_rr_arb against a packet-level round-robin reference model.
module tb_axis_rr_arb;

    localparam int unsigned S  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [S*DW-1:0]   s_tdata;
    logic [S-1:0]      s_tvalid;
    logic [S-1:0]      s_tready;
    logic [S-1:0]      s_tlast;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [SW-1:0]     gidx;
    logic              gvalid;
    logic [CW-1:0]     pcnt;

    always #5 clk = ~clk;

    axis_rr_arb #(
        .S_COUNT   (S),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .grant_idx    (gidx),
        .grant_valid  (gvalid),
        .pkt_count    (pcnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the output, where the rotation resumes, packets done.
    bit mb;
    int mo, mg, mp, mc;

    // Source state per stream.
    int          rem [S];
    logic        v   [S];
    logic        l   [S];
    logic [DW-1:0] d [S];
    logic [S-1:0] xfer;

    int vpct, rpct, maxlen;
    logic [S-1:0] en;

    typedef struct {
        int         cyc;
        int         vp;
        int         rp;
        int         ml;
        logic [3:0] m;
        bit         rst_after;
    } phase_t;

    phase_t ph [6];

    function automatic logic [S-1:0] exp_ready();
        logic [S-1:0] r;
        r = '0;
        if (mb && m_tready) r[mo] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        mb = 0; mo = 0; mg = 0; mp = 0; mc = 0;
    endtask

    task automatic model_step();
        if (!mb) begin
            for (int k = 0; k < S; k++) begin
                int j;
                j = (mp + k) % S;
                if (!mb && s_tvalid[j]) begin
                    mb = 1; mo = j; mg = j;
                end
            end
        end else if (s_tvalid[mo] && m_tready && s_tlast[mo]) begin
            mb = 0;
            mp = (mo + 1) % S;
            mc = (mc + 1) % (1 << CW);
        end
    endtask

    task automatic sources_reset();
        for (int i = 0; i < S; i++) begin
            rem[i] = 0; v[i] = 0; l[i] = 0; d[i] = '0;
        end
        xfer = '0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < S; i++) begin
            if (xfer[i]) begin
                rem[i]--;
                v[i] = 1'b0;
            end
            if (!v[i] && en[i] && ($urandom_range(99) < 32'(vpct))) begin
                if (rem[i] == 0) rem[i] = int'($urandom_range(32'(maxlen), 1));
                v[i] = 1'b1;
                d[i] = $urandom;
                l[i] = (rem[i] == 1);
            end
            s_tvalid[i]          = v[i];
            s_tlast[i]           = l[i];
            s_tdata[i*DW +: DW]  = d[i];
        end
        m_tready = ($urandom_range(99) < 32'(rpct));
    endtask

    task automatic check_outputs();
        check_eq("grant_valid", 64'(gvalid), 64'(mb));
        check_eq("grant_idx", 64'(gidx), 64'(mg));
        check_eq("pkt_count", 64'(pcnt), 64'(mc));
        check_eq("m_tvalid", 64'(m_tvalid), 64'(mb && s_tvalid[mo]));
        check_eq("s_tready", 64'(s_tready), 64'(exp_ready()));
        if (mb) begin
            check_eq("m_tdata", 64'(m_tdata), 64'(s_tdata[mo*DW +: DW]));
            check_eq("m_tlast", 64'(m_tlast), 64'(s_tlast[mo]));
        end
    endtask

    task automatic one_cycle();
        @(posedge clk);
        model_step();
        #1;
        drive_inputs();
        @(negedge clk);
        check_outputs();
        xfer = s_tvalid & exp_ready();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tready"}, 64'(s_tready), 64'(0));
        check_eq({tag, "_mvalid"}, 64'(m_tvalid), 64'(0));
        check_eq({tag, "_gvalid"}, 64'(gvalid), 64'(0));
        check_eq({tag, "_pcnt"}, 64'(pcnt), 64'(0));
        check_eq({tag, "_gidx"}, 64'(gidx), 64'(0));
    endtask

    // Assert reset asynchronously while a packet is in flight.
    task automatic reset_mid();
        int waited;
        waited = 0;
        while (!mb && waited < 100) begin
            one_cycle();
            waited++;
        end
        check_eq("rst_wait_busy", 64'(mb), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        model_reset();
        sources_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        ph[0] = '{cyc: 300, vp: 60,  rp: 70,  ml: 4, m: 4'hF,    rst_after: 1'b1};
        ph[1] = '{cyc: 80,  vp: 100, rp: 100, ml: 2, m: 4'hF,    rst_after: 1'b0};
        ph[2] = '{cyc: 150, vp: 50,  rp: 100, ml: 1, m: 4'hF,    rst_after: 1'b0};
        ph[3] = '{cyc: 200, vp: 70,  rp: 50,  ml: 5, m: 4'b1001, rst_after: 1'b1};
        ph[4] = '{cyc: 200, vp: 40,  rp: 30,  ml: 6, m: 4'b0101, rst_after: 1'b0};
        ph[5] = '{cyc: 400, vp: 80,  rp: 80,  ml: 3, m: 4'hF,    rst_after: 1'b0};

        rst_n = 1'b0;
        en = '0; vpct = 0; rpct = 0; maxlen = 1;
        model_reset();
        sources_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_init");
        rst_n = 1'b1;

        for (int p = 0; p < 6; p++) begin
            vpct   = ph[p].vp;
            rpct   = ph[p].rp;
            maxlen = ph[p].ml;
            en     = ph[p].m;
            for (int c = 0; c < ph[p].cyc; c++) one_cycle();
            if (ph[p].rst_after) reset_mid();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
